// File: rtl/ticket_vendor.sv
// Coin-operated ticket vendor: collects nickels/dimes/quarters, vends at PRICE,
// returns change or refunds on cancel. Ports: clk, rst (async low), coin/valid, cancel, change handshake.
module ticket_vendor #(
  parameter int PRICE      = 15,
  parameter int CW         = 8,
  parameter bit QUARTER_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    coin,
  input  logic          coin_valid,
  input  logic          cancel,
  input  logic          change_ack,
  output logic          ticket,
  output logic          coin_reject,
  output logic          change_valid,
  output logic [CW-1:0] change_amt,
  output logic [CW-1:0] credit,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VEND,
    RETURN
  } state_t;

  localparam logic [CW-1:0] PRICE_W = CW'(PRICE);

  state_t        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [CW-1:0] amt_q, amt_d;
  logic          ticket_q, ticket_d;
  logic          rej_q, rej_d;

  logic [CW-1:0] coin_amt;
  logic [CW-1:0] sum;
  logic [CW-1:0] over;
  logic          coin_ok;
  logic          busy_w;
  logic          cancel_hit;

  always_comb begin
    coin_amt = '0;
    unique case (coin)
      2'd0: coin_amt = '0;
      2'd1: coin_amt = CW'(5);
      2'd2: coin_amt = CW'(10);
      2'd3: coin_amt = CW'(25);
    endcase
  end

  assign coin_ok    = (coin != 2'd0) &&
                      ((coin != 2'd3) || QUARTER_EN);
  assign busy_w     = (state_q == VEND) ||
                      (state_q == RETURN);
  assign cancel_hit = (state_q == COLLECT) && cancel;
  assign sum        = credit_q + coin_amt;
  assign over       = credit_q - PRICE_W;

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    amt_d    = amt_q;
    // cancel takes priority over a coin arriving in the same cycle
    rej_d    = coin_valid &&
               (!coin_ok || busy_w || cancel_hit);
    unique case (state_q)
      IDLE, COLLECT: begin
        if (cancel_hit) begin
          amt_d    = credit_q;
          credit_d = '0;
          state_d  = RETURN;
        end else if (coin_valid && coin_ok) begin
          credit_d = sum;
          state_d  = (sum >= PRICE_W) ? VEND
                                      : COLLECT;
        end
      end
      VEND: begin
        amt_d    = over;
        credit_d = '0;
        state_d  = (over != '0) ? RETURN : IDLE;
      end
      RETURN: begin
        if (change_ack) begin
          amt_d   = '0;
          state_d = IDLE;
        end
      end
    endcase
    ticket_d = (state_d == VEND);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      amt_q    <= '0;
      ticket_q <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      amt_q    <= amt_d;
      ticket_q <= ticket_d;
      rej_q    <= rej_d;
    end
  end

  assign ticket       = ticket_q;
  assign coin_reject  = rej_q;
  assign change_valid = (state_q == RETURN);
  assign change_amt   = amt_q;
  assign credit       = credit_q;
  assign busy         = busy_w;

endmodule

// File: tb/tb_ticket_vendor.sv
// Self-checking bench for ticket_vendor: directed table, corner sequences,
// and randomized traffic against a cents-level behavioural model.
module tb_ticket_vendor;

  localparam int PRICE = 15;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    coin;
  logic          coin_valid, cancel, change_ack;
  logic          ticket, coin_reject, change_valid, busy;
  logic [CW-1:0] change_amt, credit;

  logic [1:0]    q_coin;
  logic          q_valid, q_cancel, q_ack;
  logic          q_ticket, q_rej, q_cv, q_busy;
  logic [CW-1:0] q_amt, q_credit;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  ticket_vendor #(.PRICE(PRICE), .CW(CW), .QUARTER_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .coin(coin), .coin_valid(coin_valid),
    .cancel(cancel), .change_ack(change_ack), .ticket(ticket),
    .coin_reject(coin_reject), .change_valid(change_valid),
    .change_amt(change_amt), .credit(credit), .busy(busy)
  );

  ticket_vendor #(.PRICE(PRICE), .CW(CW), .QUARTER_EN(1'b0)) dutq (
    .clk(clk), .rst(rst), .coin(q_coin), .coin_valid(q_valid),
    .cancel(q_cancel), .change_ack(q_ack), .ticket(q_ticket),
    .coin_reject(q_rej), .change_valid(q_cv),
    .change_amt(q_amt), .credit(q_credit), .busy(q_busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Behavioural model: amounts in cents, phases as flags.
  int m_credit, m_change;
  bit m_vending, m_returning, m_rej;

  task automatic m_reset();
    m_credit = 0; m_change = 0;
    m_vending = 0; m_returning = 0; m_rej = 0;
  endtask

  function automatic int cents(input int c);
    case (c)
      1: return 5;
      2: return 10;
      3: return 25;
      default: return 0;
    endcase
  endfunction

  task automatic m_step(input bit cv, input int c,
                        input bit can, input bit ack);
    bit good, is_busy, collecting;
    good       = (c != 0);
    is_busy    = m_vending || m_returning;
    collecting = !is_busy && (m_credit > 0);
    m_rej = cv && (!good || is_busy || (can && collecting));
    if (m_vending) begin
      m_change    = m_credit - PRICE;
      m_credit    = 0;
      m_vending   = 0;
      m_returning = (m_change != 0);
    end else if (m_returning) begin
      if (ack) begin
        m_returning = 0;
        m_change    = 0;
      end
    end else if (can && collecting) begin
      m_change    = m_credit;
      m_credit    = 0;
      m_returning = 1;
    end else if (cv && good) begin
      m_credit += cents(c);
      if (m_credit >= PRICE) m_vending = 1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ticket"}, int'(ticket), int'(m_vending));
    chk({tag, ".reject"}, int'(coin_reject), int'(m_rej));
    chk({tag, ".credit"}, int'(credit), m_credit);
    chk({tag, ".cvalid"}, int'(change_valid), int'(m_returning));
    chk({tag, ".amt"}, int'(change_amt), m_change);
    chk({tag, ".busy"}, int'(busy), int'(m_vending || m_returning));
  endtask

  task automatic drive(input bit cv, input int c,
                       input bit can, input bit ack);
    coin_valid = cv; coin = 2'(c);
    cancel = can; change_ack = ack;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit cv; int c; bit can; bit ack;
    bit e_tick; bit e_rej; int e_credit;
    bit e_cv; int e_amt; bit e_busy;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1, 1, 0, 0, 0, 0,  5, 0,  0, 0};
    vecs[1]  = '{1, 2, 0, 0, 1, 0, 15, 0,  0, 1};
    vecs[2]  = '{0, 0, 0, 0, 0, 0,  0, 0,  0, 0};
    vecs[3]  = '{1, 3, 0, 0, 1, 0, 25, 0,  0, 1};
    vecs[4]  = '{1, 1, 0, 0, 0, 1,  0, 1, 10, 1};
    vecs[5]  = '{0, 0, 0, 0, 0, 0,  0, 1, 10, 1};
    vecs[6]  = '{1, 2, 0, 0, 0, 1,  0, 1, 10, 1};
    vecs[7]  = '{0, 0, 0, 1, 0, 0,  0, 0,  0, 0};
    vecs[8]  = '{1, 0, 0, 0, 0, 1,  0, 0,  0, 0};
    vecs[9]  = '{1, 1, 0, 0, 0, 0,  5, 0,  0, 0};
    vecs[10] = '{1, 2, 1, 0, 0, 1,  0, 1,  5, 1};
    vecs[11] = '{0, 0, 0, 0, 0, 0,  0, 1,  5, 1};
    vecs[12] = '{0, 0, 0, 1, 0, 0,  0, 0,  0, 0};
    vecs[13] = '{0, 0, 0, 1, 0, 0,  0, 0,  0, 0};
    vecs[14] = '{0, 0, 1, 0, 0, 0,  0, 0,  0, 0};

    rst = 1'b0;
    drive(0, 0, 0, 0);
    q_coin = 2'd0; q_valid = 0; q_cancel = 0; q_ack = 0;
    #3;
    chk("rst.ticket", int'(ticket), 0);
    chk("rst.reject", int'(coin_reject), 0);
    chk("rst.credit", int'(credit), 0);
    chk("rst.cvalid", int'(change_valid), 0);
    chk("rst.amt", int'(change_amt), 0);
    chk("rst.busy", int'(busy), 0);
    tick();
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].cv, vecs[i].c, vecs[i].can, vecs[i].ack);
      tick();
      chk($sformatf("v%0d.ticket", i), int'(ticket), int'(vecs[i].e_tick));
      chk($sformatf("v%0d.reject", i), int'(coin_reject), int'(vecs[i].e_rej));
      chk($sformatf("v%0d.credit", i), int'(credit), vecs[i].e_credit);
      chk($sformatf("v%0d.cvalid", i), int'(change_valid), int'(vecs[i].e_cv));
      chk($sformatf("v%0d.amt", i), int'(change_amt), vecs[i].e_amt);
      chk($sformatf("v%0d.busy", i), int'(busy), int'(vecs[i].e_busy));
    end
    drive(0, 0, 0, 0);

    // quarter rejected when quarters are disabled
    q_valid = 1; q_coin = 2'd3;
    tick();
    q_valid = 0;
    chk("noq.reject", int'(q_rej), 1);
    chk("noq.credit", int'(q_credit), 0);
    chk("noq.ticket", int'(q_ticket), 0);
    tick();
    chk("noq.reject_drop", int'(q_rej), 0);

    // dime, then asynchronous reset between edges
    drive(1, 2, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("ar.pre_credit", int'(credit), 10);
    #2;
    rst = 1'b0;
    #1;
    chk("ar.credit", int'(credit), 0);
    chk("ar.amt", int'(change_amt), 0);
    chk("ar.busy", int'(busy), 0);
    chk("ar.cvalid", int'(change_valid), 0);
    #1;
    rst = 1'b1;
    drive(1, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("ar.post_credit", int'(credit), 5);
    chk("ar.post_ticket", int'(ticket), 0);

    // reset mid-RETURN discards pending change
    drive(1, 3, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    tick();
    chk("rr.cvalid_pre", int'(change_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rr.cvalid", int'(change_valid), 0);
    chk("rr.amt", int'(change_amt), 0);
    #1;
    rst = 1'b1;

    m_reset();
    for (int n = 0; n < 400; n++) begin
      bit cv, can, ack;
      int c;
      cv  = ($urandom_range(0, 1) == 1);
      c   = $urandom_range(0, 3);
      can = ($urandom_range(0, 6) == 0);
      ack = ($urandom_range(0, 2) == 0);
      drive(cv, c, can, ack);
      m_step(cv, c, can, ack);
      tick();
      check_model($sformatf("r%0d", n));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
